// File: rtl/crs_pkg.sv
// Shared types and LFSR definition for the constraint rejection sampler.
package crs_pkg;

    localparam int                LFSR_W    = 32;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GEN   = 2'd1,
        CHECK = 2'd2,
        OUT   = 2'd3
    } state_t;

    // One Galois step, shifting right; the taps are folded in when bit 0 falls out.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
    endfunction

endpackage

// File: rtl/sampler_lfsr32.sv
// 32-bit Galois LFSR with step enable and a seed load that can never lock up at zero.
module sampler_lfsr32
    import crs_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED_DEFAULT = 32'h1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] state
);

    // Load has priority over step; a zero seed is replaced by 1.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEED_DEFAULT;
        end else if (load) begin
            state <= (seed == '0) ? LFSR_W'(1) : seed;
        end else if (step) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/constraint_rejection_sampler.sv
// Rejection sampler: draws NUM_VARS variables from an LFSR, checks range, zero-mask
// and sum constraints, retries on failure and streams accepted samples over valid/ready.
module constraint_rejection_sampler
    import crs_pkg::*;
#(
    parameter int                NUM_VARS     = 4,
    parameter int                VAR_W        = 8,
    parameter int                CNT_W        = 16,
    parameter int                MAX_RETRY    = 16,
    parameter logic [LFSR_W-1:0] SEED_DEFAULT = 32'h1,
    localparam int               SUM_W        = VAR_W + $clog2(NUM_VARS) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      seed_load,
    input  logic [LFSR_W-1:0]         seed_val,
    input  logic                      start,
    input  logic [CNT_W-1:0]          req_count,
    input  logic [NUM_VARS*VAR_W-1:0] cfg_lo,
    input  logic [NUM_VARS*VAR_W-1:0] cfg_hi,
    input  logic [NUM_VARS*VAR_W-1:0] cfg_zero_mask,
    input  logic [SUM_W-1:0]          cfg_sum_max,
    input  logic                      abort,
    output logic                      smp_valid,
    input  logic                      smp_ready,
    output logic [NUM_VARS*VAR_W-1:0] smp_data,
    output logic                      busy,
    output logic                      done,
    output logic                      err_timeout,
    output logic [CNT_W-1:0]          acc_cnt,
    output logic [CNT_W-1:0]          rej_cnt
);

    localparam int DATA_W  = NUM_VARS * VAR_W;
    localparam int IDX_W   = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_VARS - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);

    state_t              state;
    logic [IDX_W-1:0]    gen_idx;
    logic [RETRY_W-1:0]  retry_cnt;
    logic [CNT_W-1:0]    rem_cnt;
    logic [DATA_W-1:0]   cand;
    logic [DATA_W-1:0]   cfg_lo_q;
    logic [DATA_W-1:0]   cfg_hi_q;
    logic [DATA_W-1:0]   cfg_zero_mask_q;
    logic [SUM_W-1:0]    cfg_sum_max_q;

    logic [LFSR_W-1:0]   lfsr_state;
    logic [LFSR_W-1:0]   lfsr_next;
    logic                lfsr_step_en;
    logic                lfsr_load;
    logic                unused_lfsr_hi;

    logic [NUM_VARS-1:0] var_ok;
    logic [SUM_W-1:0]    cand_sum;
    logic                cand_pass;

    // The LFSR moves only while drawing variables, so a stalled OUT freezes it.
    assign lfsr_step_en = (state == GEN) && !abort;
    assign lfsr_load    = (state == IDLE) && seed_load;

    sampler_lfsr32 #(
        .SEED_DEFAULT (SEED_DEFAULT)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .step  (lfsr_step_en),
        .load  (lfsr_load),
        .seed  (seed_val),
        .state (lfsr_state)
    );

    // Variables take the low bits of the value the LFSR steps to on the same edge.
    assign lfsr_next      = lfsr_step(lfsr_state);
    // Upper LFSR bits only feed the recurrence, never a variable.
    assign unused_lfsr_hi = ^lfsr_next;

    // Per-variable range and zero-mask checks; lo > hi simply never passes.
    for (genvar i = 0; i < NUM_VARS; i++) begin : g_eval
        logic [VAR_W-1:0] v;
        assign v         = cand[i*VAR_W +: VAR_W];
        assign var_ok[i] = (v >= cfg_lo_q[i*VAR_W +: VAR_W]) &&
                           (v <= cfg_hi_q[i*VAR_W +: VAR_W]) &&
                           ((v & cfg_zero_mask_q[i*VAR_W +: VAR_W]) == '0);
    end

    // Zero-extended sum of all variables; SUM_W is wide enough that it cannot overflow.
    // NOTE: combinational blocks use blocking assignments and assign every output first, so no latch is inferred.
    always_comb begin
        cand_sum = '0;
        for (int i = 0; i < NUM_VARS; i++) begin
            cand_sum = cand_sum + SUM_W'(cand[i*VAR_W +: VAR_W]);
        end
    end

    assign cand_pass = (&var_ok) && (cand_sum <= cfg_sum_max_q);
    assign busy      = (state != IDLE);

    // Request sequencing, retry bookkeeping and the registered stream outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            gen_idx         <= '0;
            retry_cnt       <= '0;
            rem_cnt         <= '0;
            cand            <= '0;
            cfg_lo_q        <= '0;
            cfg_hi_q        <= '0;
            cfg_zero_mask_q <= '0;
            cfg_sum_max_q   <= '0;
            smp_valid       <= 1'b0;
            smp_data        <= '0;
            done            <= 1'b0;
            err_timeout     <= 1'b0;
            acc_cnt         <= '0;
            rej_cnt         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cfg_lo_q        <= cfg_lo;
                        cfg_hi_q        <= cfg_hi;
                        cfg_zero_mask_q <= cfg_zero_mask;
                        cfg_sum_max_q   <= cfg_sum_max;
                        acc_cnt         <= '0;
                        rej_cnt         <= '0;
                        err_timeout     <= 1'b0;
                        retry_cnt       <= '0;
                        gen_idx         <= '0;
                        if (req_count == '0) begin
                            done <= 1'b1;
                        end else begin
                            rem_cnt <= req_count;
                            state   <= GEN;
                        end
                    end
                end

                GEN: begin
                    if (abort) begin
                        gen_idx <= '0;
                        state   <= IDLE;
                    end else begin
                        cand[int'(gen_idx)*VAR_W +: VAR_W] <= lfsr_next[VAR_W-1:0];
                        if (gen_idx == LAST_IDX) begin
                            gen_idx <= '0;
                            state   <= CHECK;
                        end else begin
                            gen_idx <= gen_idx + 1'b1;
                        end
                    end
                end

                CHECK: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (cand_pass) begin
                        retry_cnt <= '0;
                        state     <= OUT;
                    end else begin
                        if (rej_cnt != '1) begin
                            rej_cnt <= rej_cnt + 1'b1;
                        end
                        if (retry_cnt == RETRY_LAST) begin
                            err_timeout <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            retry_cnt <= retry_cnt + 1'b1;
                            state     <= GEN;
                        end
                    end
                end

                OUT: begin
                    if (abort) begin
                        smp_valid <= 1'b0;
                        state     <= IDLE;
                    end else if (!smp_valid) begin
                        smp_valid <= 1'b1;
                        smp_data  <= cand;
                    end else if (smp_ready) begin
                        smp_valid <= 1'b0;
                        acc_cnt   <= acc_cnt + 1'b1;
                        rem_cnt   <= rem_cnt - 1'b1;
                        if (rem_cnt == CNT_W'(1)) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            state <= GEN;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_constraint_rejection_sampler.sv
// Self-checking bench: a behavioural model predicts accepted samples and counters,
// a monitor compares every handshake against the expected-sample queue.
module tb_constraint_rejection_sampler;

    localparam int NV = 4;
    localparam int VW = 8;
    localparam int CW = 16;
    localparam int MR = 16;
    localparam int SW = VW + $clog2(NV) + 1;
    localparam int DW = NV * VW;

    logic          clk = 1'b0;
    logic          rst;
    logic          seed_load;
    logic [31:0]   seed_val;
    logic          start;
    logic [CW-1:0] req_count;
    logic [DW-1:0] cfg_lo;
    logic [DW-1:0] cfg_hi;
    logic [DW-1:0] cfg_zero_mask;
    logic [SW-1:0] cfg_sum_max;
    logic          abort;
    logic          smp_valid;
    logic          smp_ready;
    logic [DW-1:0] smp_data;
    logic          busy;
    logic          done;
    logic          err_timeout;
    logic [CW-1:0] acc_cnt;
    logic [CW-1:0] rej_cnt;

    constraint_rejection_sampler #(
        .NUM_VARS     (NV),
        .VAR_W        (VW),
        .CNT_W        (CW),
        .MAX_RETRY    (MR),
        .SEED_DEFAULT (32'h1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .seed_load     (seed_load),
        .seed_val      (seed_val),
        .start         (start),
        .req_count     (req_count),
        .cfg_lo        (cfg_lo),
        .cfg_hi        (cfg_hi),
        .cfg_zero_mask (cfg_zero_mask),
        .cfg_sum_max   (cfg_sum_max),
        .abort         (abort),
        .smp_valid     (smp_valid),
        .smp_ready     (smp_ready),
        .smp_data      (smp_data),
        .busy          (busy),
        .done          (done),
        .err_timeout   (err_timeout),
        .acc_cnt       (acc_cnt),
        .rej_cnt       (rej_cnt)
    );

    always #5 clk = ~clk;

    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] exp_q[$];
    logic [31:0]   m_lfsr;
    int            t_lo, t_hi, t_mask, t_smax;
    int            e_acc, e_rej;
    bit            e_to;
    int            done_seen = 0;
    bit            rand_ready = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference LFSR rule: shift right, xor taps when the dropped bit was 1.
    function automatic logic [31:0] m_step(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    // Does a sample satisfy the current bench configuration?
    function automatic bit m_pass(input logic [DW-1:0] s);
        int sum;
        int v;
        sum = 0;
        for (int i = 0; i < NV; i++) begin
            v = int'(s[i*VW +: VW]);
            if (v < t_lo || v > t_hi || (v & t_mask) != 0) return 1'b0;
            sum += v;
        end
        return sum <= t_smax;
    endfunction

    // Predict one whole request: accepted samples go to the queue, counters to e_*.
    task automatic model_request(input int req);
        int            retry;
        logic [DW-1:0] s;
        retry = 0;
        e_acc = 0;
        e_rej = 0;
        e_to  = 1'b0;
        while (e_acc < req && !e_to) begin
            for (int i = 0; i < NV; i++) begin
                m_lfsr = m_step(m_lfsr);
                s[i*VW +: VW] = m_lfsr[VW-1:0];
            end
            if (m_pass(s)) begin
                exp_q.push_back(s);
                e_acc++;
                retry = 0;
            end else begin
                e_rej++;
                retry++;
                if (retry == MR) e_to = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) smp_ready = ($urandom_range(3) != 0);
    endtask

    task automatic set_cfg(input int lo, input int hi, input int mask, input int smax);
        t_lo = lo; t_hi = hi; t_mask = mask; t_smax = smax;
        for (int i = 0; i < NV; i++) begin
            cfg_lo[i*VW +: VW]        = VW'(lo);
            cfg_hi[i*VW +: VW]        = VW'(hi);
            cfg_zero_mask[i*VW +: VW] = VW'(mask);
        end
        cfg_sum_max = SW'(smax);
    endtask

    task automatic issue(input int req, input bit do_seed, input logic [31:0] sv);
        if (do_seed) m_lfsr = (sv == 32'h0) ? 32'h1 : sv;
        model_request(req);
        seed_load = do_seed;
        seed_val  = sv;
        req_count = CW'(req);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        seed_load = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check("idle_in_time", busy, 0);
        tick();
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (!smp_valid && n < budget) begin
            tick();
            n++;
        end
        check("valid_in_time", smp_valid, 1);
    endtask

    task automatic apply_reset();
        rst = 1'b1; start = 1'b0; seed_load = 1'b0; seed_val = '0; abort = 1'b0;
        req_count = '0; smp_ready = 1'b0; rand_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        m_lfsr = 32'h1;
        tick();
    endtask

    // Scoreboard monitor: every handshake that is not overridden by abort is a transfer.
    always @(negedge clk) begin
        if (!rst && smp_valid && smp_ready && !abort) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_sample: got %0h want none", smp_data);
            end else begin
                check("sample_data", smp_data, exp_q.pop_front());
            end
            check("sample_constraints", m_pass(smp_data), 1);
        end
        if (!rst && done) done_seen++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int nreq;
        int acc_total;
        cfg_lo = '0; cfg_hi = '0; cfg_zero_mask = '0; cfg_sum_max = '0;

        // Reset state
        apply_reset();
        check("rst_valid", smp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err_timeout, 0);
        check("rst_acc", acc_cnt, 0);
        check("rst_rej", rej_cnt, 0);
        check("rst_data", smp_data, 0);
        check("rst_lfsr", dut.u_lfsr.state, 32'h1);

        // 1: unconstrained, three samples, first valid six edges after start
        set_cfg(0, 255, 0, 2047);
        smp_ready = 1'b1;
        d0 = done_seen;
        issue(3, 1'b0, 32'h0);
        repeat (5) tick();
        check("t1_valid_edge5", smp_valid, 0);
        tick();
        check("t1_valid_edge6", smp_valid, 1);
        wait_idle(200);
        check("t1_acc", acc_cnt, e_acc);
        check("t1_rej", rej_cnt, e_rej);
        check("t1_err", err_timeout, 0);
        check("t1_done", done_seen - d0, 1);
        check("t1_drained", exp_q.size(), 0);
        // zero-length request: done next cycle, no busy
        req_count = '0; start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_req0_done", done, 1);
        check("t1_req0_busy", busy, 0);
        tick();
        check("t1_req0_pulse", done, 0);

        // 2: impossible constraints hit the retry limit
        apply_reset();
        set_cfg(8'h2A, 8'h2A, 0, 2047);
        smp_ready = 1'b1;
        d0 = done_seen;
        issue(4, 1'b1, 32'h1);
        wait_idle(400);
        check("t2_err", err_timeout, e_to);
        check("t2_acc", acc_cnt, e_acc);
        check("t2_rej", rej_cnt, e_rej);
        check("t2_busy", busy, 0);
        check("t2_no_done", done_seen - d0, e_to ? 0 : 1);
        // start clears the sticky error
        req_count = '0; start = 1'b1;
        tick();
        start = 1'b0;
        check("t2_err_cleared", err_timeout, 0);

        // 3: sink stall holds data and freezes the LFSR
        apply_reset();
        set_cfg(0, 255, 0, 2047);
        smp_ready = 1'b0;
        issue(1, 1'b0, 32'h0);
        wait_valid(50);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("t3_valid", smp_valid, 1);
            check("t3_data", smp_data, exp_q[0]);
            check("t3_lfsr", dut.u_lfsr.state, m_lfsr);
            check("t3_acc", acc_cnt, 0);
            check("t3_rej", rej_cnt, e_rej);
        end
        smp_ready = 1'b1;
        wait_idle(50);
        check("t3_acc_after", acc_cnt, 1);

        // 5: reset in the middle of generation, then a fresh identical stream
        apply_reset();
        set_cfg(0, 255, 0, 2047);
        smp_ready = 1'b1;
        issue(3, 1'b0, 32'h0);
        begin
            int n;
            n = 0;
            while (acc_cnt != 1 && n < 100) begin
                tick();
                n++;
            end
        end
        check("t5_first_acc", acc_cnt, 1);
        tick();
        #3;
        rst = 1'b1;
        #1;
        check("t5_rst_valid", smp_valid, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_acc", acc_cnt, 0);
        check("t5_rst_data", smp_data, 0);
        exp_q.delete();
        m_lfsr = 32'h1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        issue(3, 1'b0, 32'h0);
        wait_idle(200);
        check("t5_acc", acc_cnt, 3);
        check("t5_drained", exp_q.size(), 0);

        // 6: zero seed guard, then abort beats a same-cycle transfer
        apply_reset();
        seed_load = 1'b1; seed_val = 32'h1234_5678;
        tick();
        check("t6_seed_load", dut.u_lfsr.state, 32'h1234_5678);
        seed_val = 32'h0;
        tick();
        seed_load = 1'b0;
        check("t6_seed_zero", dut.u_lfsr.state, 32'h1);
        set_cfg(0, 255, 0, 2047);
        smp_ready = 1'b0;
        d0 = done_seen;
        issue(3, 1'b0, 32'h0);
        wait_valid(50);
        smp_ready = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t6_abort_busy", busy, 0);
        check("t6_abort_valid", smp_valid, 0);
        check("t6_abort_acc", acc_cnt, 0);
        tick();
        check("t6_abort_no_done", done_seen - d0, 0);
        exp_q.delete();

        // 4: even variables with a small sum budget, 50 samples across requests
        apply_reset();
        set_cfg(0, 255, 1, 256);
        rand_ready = 1'b1;
        acc_total = 0;
        nreq = 0;
        while (acc_total < 50 && nreq < 1000) begin
            issue(50 - acc_total, nreq == 0, $urandom);
            wait_idle(5000);
            check("t4_acc", acc_cnt, e_acc);
            check("t4_rej", rej_cnt, e_rej);
            check("t4_err", err_timeout, e_to);
            acc_total += int'(acc_cnt);
            nreq++;
        end
        rand_ready = 1'b0;
        check("t4_total_acc", acc_total, 50);
        check("t4_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
